// File: rtl/bus_src_fifo.sv
// Per-terminal show-ahead source FIFO feeding the parallel bus: head packet is
// presented on D_pop while pndng is high; overflow/underflow are sticky.
module bus_src_fifo #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int id      = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    output logic                     full,
    input  logic                     pop,
    output logic [pckg_sz-1:0]       D_pop,
    output logic                     pndng,
    output logic [$clog2(depth):0]   count,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [pckg_sz-1:0] r_mem [depth];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_pndng;
    logic               r_full;
    logic [pckg_sz-1:0] r_d_pop;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [AW-1:0]      w_wr_ptr_nxt;
    logic [AW-1:0]      w_rd_ptr_nxt;
    logic [CW-1:0]      w_count_nxt;
    logic [pckg_sz-1:0] w_head_nxt;

    always_comb begin
        w_wr_ok      = push & (~r_full | pop);
        w_rd_ok      = pop & r_pndng;
        w_wr_ptr_nxt = w_wr_ok ? r_wr_ptr + AW'(1) : r_wr_ptr;
        w_rd_ptr_nxt = w_rd_ok ? r_rd_ptr + AW'(1) : r_rd_ptr;
        w_count_nxt  = r_count;
        unique case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
        // The slot being written this edge is not yet in r_mem, so bypass it
        // when it becomes the new head (empty push, or 1-deep push+pop).
        if (w_count_nxt == '0)
            w_head_nxt = '0;
        else if (w_wr_ok && (r_wr_ptr == w_rd_ptr_nxt))
            w_head_nxt = D_push;
        else
            w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    // NOTE: storage is deliberately left out of reset; count alone decides
    // which entries are live, so stale contents are never observable.
    always_ff @(posedge clock) begin
        if (w_wr_ok)
            r_mem[r_wr_ptr] <= D_push;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pndng     <= 1'b0;
            r_full      <= 1'b0;
            r_d_pop     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_pndng     <= (w_count_nxt != '0);
            r_full      <= (w_count_nxt == FULL_CNT);
            r_d_pop     <= w_head_nxt;
            // A new error in the same cycle as clr_err leaves the flag set.
            r_overflow  <= (push & r_full & ~pop) | (r_overflow & ~clr_err);
            r_underflow <= (pop & ~r_pndng) | (r_underflow & ~clr_err);
        end
    end

    assign full      = r_full;
    assign pndng     = r_pndng;
    assign count     = r_count;
    assign D_pop     = r_d_pop;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    a_count_max: assert property (@(posedge clock) disable iff (!reset)
        r_count <= FULL_CNT)
        else $error("bus_src_fifo[%0d]: count above depth", id);
    a_pndng_cnt: assert property (@(posedge clock) disable iff (!reset)
        !(r_pndng && (r_count == '0)))
        else $error("bus_src_fifo[%0d]: pndng with zero count", id);
    a_full_pndng: assert property (@(posedge clock) disable iff (!reset)
        !r_full || r_pndng)
        else $error("bus_src_fifo[%0d]: full without pndng", id);

endmodule

// File: tb/tb_bus_src_fifo.sv
// Directed self-checking bench for bus_src_fifo (pckg_sz=16, depth=8).
module tb_bus_src_fifo;

    logic        clock;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        full;
    logic        pop;
    logic [15:0] D_pop;
    logic        pndng;
    logic [3:0]  count;
    logic        clr_err;
    logic        overflow;
    logic        underflow;

    int total;
    int bad;

    bus_src_fifo #(.pckg_sz(16), .depth(8), .id(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .D_push    (D_push),
        .full      (full),
        .pop       (pop),
        .D_pop     (D_pop),
        .pndng     (pndng),
        .count     (count),
        .clr_err   (clr_err),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; D_push = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #12;
        total++; if (pndng !== 1'b0) begin bad++; $display("FAIL rst_pndng got=%b exp=0", pndng); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (D_pop !== 16'h0) begin bad++; $display("FAIL rst_dpop got=%h exp=0000", D_pop); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {overflow, underflow}); end
        @(negedge clock);
        reset = 1'b1;
        step();
        total++; if ({pndng, full, count} !== 6'b0) begin bad++; $display("FAIL post_rst_idle got=%b exp=000000", {pndng, full, count}); end
    endtask

    task automatic test_single(input string tag);
        push = 1'b1; D_push = 16'hA5A5;
        step();
        push = 1'b0;
        total++; if (pndng !== 1'b1) begin bad++; $display("FAIL %s_pndng got=%b exp=1", tag, pndng); end
        total++; if (D_pop !== 16'hA5A5) begin bad++; $display("FAIL %s_dpop got=%h exp=a5a5", tag, D_pop); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL %s_count got=%0d exp=1", tag, count); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        total++; if (pndng !== 1'b0) begin bad++; $display("FAIL %s_pop_pndng got=%b exp=0", tag, pndng); end
        total++; if (D_pop !== 16'h0) begin bad++; $display("FAIL %s_pop_dpop got=%h exp=0000", tag, D_pop); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL %s_pop_count got=%0d exp=0", tag, count); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL %s_no_udf got=%b exp=0", tag, underflow); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; D_push = 16'(i);
            step();
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
        D_push = 16'h0009;
        step();
        push = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
        for (int i = 1; i <= 8; i++) begin
            total++; if (D_pop !== 16'(i)) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, D_pop, 16'(i)); end
            pop = 1'b1;
            step();
        end
        pop = 1'b0;
        total++; if ({pndng, count} !== 5'b0) begin bad++; $display("FAIL drain_empty got=%b exp=00000", {pndng, count}); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; D_push = 16'h0010 + 16'(i);
            step();
        end
        D_push = 16'h00FF; pop = 1'b1;
        step();
        push = 1'b0; pop = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", count); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full got=%b exp=1", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_no_ovf got=%b exp=0", overflow); end
        for (int i = 2; i <= 9; i++) begin
            logic [15:0] exp_v;
            exp_v = (i == 9) ? 16'h00FF : 16'h0010 + 16'(i);
            total++; if (D_pop !== exp_v) begin bad++; $display("FAIL fpp_drain_%0d got=%h exp=%h", i, D_pop, exp_v); end
            pop = 1'b1;
            step();
        end
        pop = 1'b0;
        total++; if (pndng !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", pndng); end
    endtask

    task automatic test_empty_push_pop();
        push = 1'b1; pop = 1'b1; D_push = 16'h1234;
        step();
        push = 1'b0; pop = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL epp_udf got=%b exp=1", underflow); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL epp_count got=%0d exp=1", count); end
        total++; if (D_pop !== 16'h1234) begin bad++; $display("FAIL epp_dpop got=%h exp=1234", D_pop); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL epp_clr got=%b exp=0", underflow); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL epp_clr_count got=%0d exp=1", count); end
        // clr_err together with a fresh underflow: set must win.
        pop = 1'b1;
        step();
        clr_err = 1'b1;
        step();
        pop = 1'b0; clr_err = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", underflow); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            logic [15:0] v;
            v = 16'h3000 + 16'(i * 7);
            push = 1'b1; D_push = v;
            step();
            push = 1'b0;
            total++; if (D_pop !== v || count !== 4'd1) begin bad++; $display("FAIL wrap_%0d got=%h/%0d exp=%h/1", i, D_pop, count, v); end
            pop = 1'b1;
            step();
            pop = 1'b0;
            if (count !== 4'd0) begin bad++; $display("FAIL wrap_cnt_%0d got=%0d exp=0", i, count); end
            total++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; D_push = 16'hBE00 + 16'(i);
            step();
        end
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        total++; if (count !== 4'd4) begin bad++; $display("FAIL mid_pre_count got=%0d exp=4", count); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (pndng !== 1'b0) begin bad++; $display("FAIL mid_pndng got=%b exp=0", pndng); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", count); end
        total++; if ({full, overflow, underflow} !== 3'b000) begin bad++; $display("FAIL mid_flags got=%b exp=000", {full, overflow, underflow}); end
        total++; if (D_pop !== 16'h0) begin bad++; $display("FAIL mid_dpop got=%h exp=0000", D_pop); end
        step();
        @(negedge clock);
        reset = 1'b1;
        step();
        test_single("post_mid");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single("single");
        test_fill_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_src_fifo.md
Name: bus_src_fifo

Overview:
Per-terminal source FIFO that sits directly upstream of the parallel bus DUT, one instance per driver slot [bit][drvr]. The verification driver (or a producer agent) writes packets in; the bus arbitrates on pndng, pops with pop and samples D_pop. Show-ahead organisation: the head packet is visible on D_pop whenever pndng is high. Sticky error flags report protocol misuse to the scoreboard.

Parameters:
pckg_sz, 16, packet width in bits (matches the bus interface D_pop/D_push width)
depth, 8, FIFO entries; power of two, >= 2
id, 0, terminal index, for assertion messages only; no functional effect

Ports:
clock  input  1  single system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset; asserted when 0
push  input  1  write strobe from producer; qualifies D_push
D_push  input  pckg_sz  packet to enqueue
full  output  1  FIFO holds depth entries
pop  input  1  read strobe from bus DUT
D_pop  output  pckg_sz  head packet, valid while pndng=1
pndng  output  1  FIFO non-empty (pending packet for the bus)
count  output  $clog2(depth)+1  current occupancy, 0..depth
clr_err  input  1  synchronous clear of the sticky error flags
overflow  output  1  sticky: push seen while full and no pop
underflow  output  1  sticky: pop seen while empty

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, pndng=0, full=0, D_pop=0, overflow=0, underflow=0. Storage contents need not be cleared. Release is synchronous to clock; the first accepted operation is on the first posedge with reset=1.
- Storage: depth x pckg_sz register array, wr_ptr/rd_ptr of $clog2(depth) bits, wrapping modulo depth. No pointer-compare ambiguity: full and empty are derived from count.
- Outputs are registered: pndng = (count!=0), full = (count==depth), D_pop = mem[rd_ptr], all updated from post-edge state. No combinational path exists from push/pop to any output.
- Write accept: wr_ok = push & (~full | pop). Accepted data appears at D_pop on the next cycle at the earliest (1-cycle write-to-pndng latency when empty).
- Read accept: rd_ok = pop & pndng. The head advances on the posedge; the next entry (or 0 if now empty) is on D_pop after that edge. The bus samples D_pop in the same cycle it asserts pop.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Simultaneous push+pop while full: both accepted, count stays depth, full stays 1, no overflow.
- Simultaneous push+pop while empty: push accepted, pop rejected (pndng=0), underflow set, count becomes 1.
- Push while full without pop: data dropped, pointers unchanged, overflow<=1.
- Pop while empty: no state change except underflow<=1; D_pop stays 0.
- Sticky flags are held until clr_err=1 (cleared on that posedge) or reset. If clr_err and a new error occur in the same cycle, the flag ends at 1 (set wins).
- When empty, D_pop is forced to 0 (not stale data), so the scoreboard cannot match ghosts.
- Reset mid-operation: all in-flight contents are discarded; pndng falls asynchronously with reset.
- Embedded assertions (disabled during reset): count<=depth; never pndng&&count==0; full implies pndng.

Test Plan:
- Reset then a single push of 16'hA5A5 -> the next cycle has pndng=1, D_pop=16'hA5A5, count=1. Pop one cycle -> the following cycle has pndng=0, D_pop=0, count=0.
- Push 8 packets 0x0001..0x0008 back-to-back (depth=8) -> full=1 and count=8 after the 8th edge. A 9th push of 0x0009 -> overflow=1, and the pop sequence returns 0x0001..0x0008 in order.
- Full FIFO, push 0x00FF with pop in the same cycle -> count remains 8, full remains 1, overflow=0. After draining, 0x00FF is the last packet out.
- Empty FIFO, push 0x1234 with pop in the same cycle -> underflow=1, count=1, D_pop=0x1234 next cycle. Assert clr_err -> underflow=0 next cycle.
- 20 alternating push/pop pairs to force wrap-around -> output order equals input order and count never exceeds 1.
- Fill with 5 entries, drop reset=0 mid-cycle -> pndng, count, full and flags are 0 immediately without waiting for a clock edge. After release, a fresh push/pop behaves as in the first scenario.
